// File: rtl/pipe_id_ex_if.sv
// pipe_id_ex_if: ID-side inputs, MEM/WB forwarding sources and EX-side outputs of the ID/EX stage
interface pipe_id_ex_if #(parameter int CTRL_W = 12);
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [31:0]       id_rdata1;
  logic [31:0]       id_rdata2;
  logic [31:0]       id_imm;
  logic [4:0]        id_wdst;
  logic              id_reg_we;
  logic              id_mem_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  logic              ex_stall;
  logic              mem_we;
  logic [4:0]        mem_dst;
  logic [31:0]       mem_result;
  logic              wb_we;
  logic [4:0]        wb_dst;
  logic [31:0]       wb_data;
  logic              stall_id;
  logic              ex_valid;
  logic              ex_reg_we;
  logic              ex_mem_rd;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_wdst;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       ex_op1;
  logic [31:0]       ex_op2;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;
  modport master (
    output id_valid, id_pc, id_rs, id_rt, id_use_rs, id_use_rt, id_rdata1, id_rdata2,
           id_imm, id_wdst, id_reg_we, id_mem_rd, id_ctrl, flush, ex_stall,
           mem_we, mem_dst, mem_result, wb_we, wb_dst, wb_data,
    input  stall_id, ex_valid, ex_reg_we, ex_mem_rd, ex_pc, ex_imm, ex_rs, ex_rt,
           ex_wdst, ex_ctrl, ex_op1, ex_op2, fwd_sel1, fwd_sel2
  );
  modport slave (
    input  id_valid, id_pc, id_rs, id_rt, id_use_rs, id_use_rt, id_rdata1, id_rdata2,
           id_imm, id_wdst, id_reg_we, id_mem_rd, id_ctrl, flush, ex_stall,
           mem_we, mem_dst, mem_result, wb_we, wb_dst, wb_data,
    output stall_id, ex_valid, ex_reg_we, ex_mem_rd, ex_pc, ex_imm, ex_rs, ex_rt,
           ex_wdst, ex_ctrl, ex_op1, ex_op2, fwd_sel1, fwd_sel2
  );
endinterface

// File: rtl/pipe_id_ex.sv
// pipe_id_ex: ID/EX pipeline register with MEM/WB operand forwarding, load-use bubbles, hold and flush
module pipe_id_ex #(parameter int CTRL_W = 12) (
  input logic   clk,
  input logic   rst_n,
  pipe_id_ex_if.slave p
);
  logic              valid_q, valid_d;
  logic              reg_we_q, reg_we_d;
  logic              mem_rd_q, mem_rd_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       imm_q, imm_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        wdst_q, wdst_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic              haz;
  logic              hold;
  logic              bub;
  logic [1:0]        sel1;
  logic [1:0]        sel2;
  logic [31:0]       op1;
  logic [31:0]       op2;
  // load in EX whose destination is read by the ID instruction
  always_comb begin
    haz = valid_q & mem_rd_q & reg_we_q & (wdst_q != 5'd0) & p.id_valid &
          ((p.id_use_rs & (p.id_rs == wdst_q)) | (p.id_use_rt & (p.id_rt == wdst_q)));
    hold = p.ex_stall;
    bub = p.flush | haz | ~p.id_valid;
  end
  // operand forwarding: $0 never forwards, MEM beats WB
  always_comb begin
    sel1 = (rs_q == 5'd0) ? 2'b00 : (p.mem_we && p.mem_dst == rs_q) ? 2'b01 :
           (p.wb_we && p.wb_dst == rs_q) ? 2'b10 : 2'b00;
    sel2 = (rt_q == 5'd0) ? 2'b00 : (p.mem_we && p.mem_dst == rt_q) ? 2'b01 :
           (p.wb_we && p.wb_dst == rt_q) ? 2'b10 : 2'b00;
    op1 = (sel1 == 2'b01) ? p.mem_result : (sel1 == 2'b10) ? p.wb_data : op1_q;
    op2 = (sel2 == 2'b01) ? p.mem_result : (sel2 == 2'b10) ? p.wb_data : op2_q;
  end
  // next state: hold (refreshing operands with forwarded values), else bubble, else capture
  always_comb begin
    valid_d  = hold ? valid_q  : bub ? 1'b0 : 1'b1;
    reg_we_d = hold ? reg_we_q : bub ? 1'b0 : p.id_reg_we;
    mem_rd_d = hold ? mem_rd_q : bub ? 1'b0 : p.id_mem_rd;
    pc_d     = hold ? pc_q     : bub ? 32'd0 : p.id_pc;
    imm_d    = hold ? imm_q    : bub ? 32'd0 : p.id_imm;
    rs_d     = hold ? rs_q     : bub ? 5'd0 : p.id_rs;
    rt_d     = hold ? rt_q     : bub ? 5'd0 : p.id_rt;
    wdst_d   = hold ? wdst_q   : bub ? 5'd0 : p.id_wdst;
    ctrl_d   = hold ? ctrl_q   : bub ? '0 : p.id_ctrl;
    op1_d    = hold ? op1      : bub ? 32'd0 : p.id_rdata1;
    op2_d    = hold ? op2      : bub ? 32'd0 : p.id_rdata2;
  end
  // pipeline register, async reset discards the held instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
      mem_rd_q <= 1'b0;
      pc_q     <= 32'd0;
      imm_q    <= 32'd0;
      rs_q     <= 5'd0;
      rt_q     <= 5'd0;
      wdst_q   <= 5'd0;
      ctrl_q   <= '0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      reg_we_q <= reg_we_d;
      mem_rd_q <= mem_rd_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      wdst_q   <= wdst_d;
      ctrl_q   <= ctrl_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end
  assign p.stall_id  = p.ex_stall | (haz & ~p.flush);
  assign p.ex_valid  = valid_q;
  assign p.ex_reg_we = reg_we_q;
  assign p.ex_mem_rd = mem_rd_q;
  assign p.ex_pc     = pc_q;
  assign p.ex_imm    = imm_q;
  assign p.ex_rs     = rs_q;
  assign p.ex_rt     = rt_q;
  assign p.ex_wdst   = wdst_q;
  assign p.ex_ctrl   = ctrl_q;
  assign p.ex_op1    = op1;
  assign p.ex_op2    = op2;
  assign p.fwd_sel1  = sel1;
  assign p.fwd_sel2  = sel2;
endmodule

// File: tb/tb_pipe_id_ex.sv
// tb_pipe_id_ex: directed checks of capture, forwarding, load-use bubble, hold refresh, flush and reset
module tb_pipe_id_ex;
  logic clk;
  logic rst_n;
  int tests;
  int fails;
  pipe_id_ex_if #(.CTRL_W(12)) b ();
  pipe_id_ex #(.CTRL_W(12)) dut (.clk(clk), .rst_n(rst_n), .p(b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic id_set(input logic v, input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [4:0] wd, input logic we, input logic ld);
    b.id_valid = v; b.id_pc = pc; b.id_rs = rs; b.id_rt = rt; b.id_use_rs = urs; b.id_use_rt = urt;
    b.id_rdata1 = d1; b.id_rdata2 = d2; b.id_wdst = wd; b.id_reg_we = we; b.id_mem_rd = ld;
    b.id_imm = pc + 32'h7; b.id_ctrl = pc[11:0] ^ 12'hABC;
  endtask
  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    b.flush = 0; b.ex_stall = 0;
    b.mem_we = 0; b.mem_dst = 0; b.mem_result = 0;
    b.wb_we = 0; b.wb_dst = 0; b.wb_data = 0;
    step();
    step();
    rst_n = 1'b1;
    // plain capture
    id_set(1, 32'h100, 5'd1, 5'd2, 1, 1, 32'h11, 32'h22, 5'd3, 1, 0);
    step();
    chk("cap_valid", 32'(b.ex_valid), 32'd1);
    chk("cap_op1", b.ex_op1, 32'h11);
    chk("cap_op2", b.ex_op2, 32'h22);
    chk("cap_sel", {28'd0, b.fwd_sel1, b.fwd_sel2}, 32'd0);
    chk("cap_pc", b.ex_pc, 32'h100);
    chk("cap_imm", b.ex_imm, 32'h107);
    chk("cap_ctrl", 32'(b.ex_ctrl), 32'h100 ^ 32'hABC);
    chk("cap_wdst_we", {26'd0, b.ex_wdst, b.ex_reg_we}, {26'd0, 5'd3, 1'b1});
    // forwarding priority
    id_set(1, 32'h104, 5'd5, 5'd0, 1, 1, 32'h55, 32'h0, 5'd6, 1, 0);
    step();
    b.mem_we = 1; b.mem_dst = 5; b.mem_result = 32'hAAAA;
    b.wb_we = 1; b.wb_dst = 5; b.wb_data = 32'hBBBB;
    #1;
    chk("fwd_mem_op1", b.ex_op1, 32'hAAAA);
    chk("fwd_mem_sel1", 32'(b.fwd_sel1), 32'd1);
    b.mem_we = 0;
    #1;
    chk("fwd_wb_op1", b.ex_op1, 32'hBBBB);
    chk("fwd_wb_sel1", 32'(b.fwd_sel1), 32'd2);
    b.mem_we = 1; b.mem_dst = 0; b.wb_dst = 0;
    #1;
    chk("fwd_r0_op2", b.ex_op2, 32'd0);
    chk("fwd_r0_sel2", 32'(b.fwd_sel2), 32'd0);
    chk("fwd_r0_op1", b.ex_op1, 32'h55);
    b.mem_we = 0; b.wb_we = 0;
    // reset mid-stream, asserted between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(b.ex_valid), 32'd0);
    chk("rst_pc", b.ex_pc, 32'd0);
    chk("rst_ops", b.ex_op1 | b.ex_op2, 32'd0);
    chk("rst_ctrl", 32'(b.ex_ctrl), 32'd0);
    step();
    chk("rst_edge_valid", 32'(b.ex_valid), 32'd0);
    rst_n = 1'b1;
    // load-use: load to r8 in EX, consumer reads r8
    id_set(1, 32'h200, 5'd1, 5'd2, 1, 0, 32'h1, 32'h2, 5'd8, 1, 1);
    step();
    id_set(1, 32'h204, 5'd8, 5'd9, 1, 1, 32'hDEAD, 32'h99, 5'd10, 1, 0);
    #1;
    chk("lu_stall", 32'(b.stall_id), 32'd1);
    step();
    chk("lu_bubble", 32'(b.ex_valid), 32'd0);
    chk("lu_bubble_rs", 32'(b.ex_rs), 32'd0);
    chk("lu_bubble_ctrl", 32'(b.ex_ctrl), 32'd0);
    chk("lu_stall_off", 32'(b.stall_id), 32'd0);
    step();
    b.mem_we = 1; b.mem_dst = 8; b.mem_result = 32'hCAFE;
    #1;
    chk("lu_valid", 32'(b.ex_valid), 32'd1);
    chk("lu_op1", b.ex_op1, 32'hCAFE);
    chk("lu_sel1", 32'(b.fwd_sel1), 32'd1);
    chk("lu_op2", b.ex_op2, 32'h99);
    // hold with WB refresh of ex_rt = r9 in the first stalled cycle only
    b.mem_we = 0;
    b.ex_stall = 1;
    b.wb_we = 1; b.wb_dst = 9; b.wb_data = 32'h1234;
    #1;
    chk("hold_stall_id", 32'(b.stall_id), 32'd1);
    chk("hold_c1_op2", b.ex_op2, 32'h1234);
    step();
    b.wb_we = 0;
    id_set(1, 32'h300, 5'd3, 5'd4, 1, 1, 32'h5, 32'h6, 5'd7, 0, 0);
    #1;
    chk("hold_c2_op2", b.ex_op2, 32'h1234);
    chk("hold_c2_sel2", 32'(b.fwd_sel2), 32'd0);
    step();
    chk("hold_c3_op2", b.ex_op2, 32'h1234);
    chk("hold_c3_pc", b.ex_pc, 32'h204);
    chk("hold_c3_rs_rt", {22'd0, b.ex_rs, b.ex_rt}, {22'd0, 5'd8, 5'd9});
    chk("hold_c3_wdst", 32'(b.ex_wdst), 32'd10);
    b.ex_stall = 0;
    // flush together with hazard
    id_set(1, 32'h400, 5'd1, 5'd2, 1, 1, 32'h1, 32'h2, 5'd8, 1, 1);
    step();
    id_set(1, 32'h404, 5'd8, 5'd2, 1, 1, 32'h1, 32'h2, 5'd4, 1, 0);
    b.flush = 1;
    #1;
    chk("fh_stall_id", 32'(b.stall_id), 32'd0);
    step();
    chk("fh_bubble", 32'(b.ex_valid), 32'd0);
    chk("fh_bubble_pc", b.ex_pc, 32'd0);
    b.flush = 0;
    id_set(1, 32'h500, 5'd1, 5'd2, 1, 1, 32'h1, 32'h2, 5'd4, 1, 0);
    step();
    chk("fs_pc", b.ex_pc, 32'h500);
    b.flush = 1; b.ex_stall = 1;
    id_set(1, 32'h504, 5'd1, 5'd2, 1, 1, 32'h1, 32'h2, 5'd4, 1, 0);
    step();
    chk("fs_hold_valid", 32'(b.ex_valid), 32'd1);
    chk("fs_hold_pc", b.ex_pc, 32'h500);
    b.flush = 0; b.ex_stall = 0;
    // load to $0 never raises a hazard; invalid ID loads a bubble
    id_set(1, 32'h600, 5'd1, 5'd2, 1, 1, 32'h1, 32'h2, 5'd0, 1, 1);
    step();
    id_set(1, 32'h604, 5'd0, 5'd0, 1, 1, 32'h0, 32'h0, 5'd4, 1, 0);
    #1;
    chk("r0_no_haz", 32'(b.stall_id), 32'd0);
    id_set(0, 32'h608, 5'd1, 5'd2, 1, 1, 32'h1, 32'h2, 5'd4, 1, 0);
    step();
    chk("idv0_bubble", 32'(b.ex_valid), 32'd0);
    chk("idv0_we", 32'(b.ex_reg_we), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
